// File: rtl/fila_escrita_registradores_if.sv
// Signal bundle for the register-file write-back queue: producer handshakes, drain port,
// bypass lookup and occupancy status.
interface fila_escrita_registradores_if #(
    parameter int unsigned PROFUNDIDADE = 4,
    parameter int unsigned LARGURA_DADO = 32
);
    localparam int unsigned LARGURA_OCUPACAO = $clog2(PROFUNDIDADE) + 1;

    logic                        ula_valido;
    logic [4:0]                  ula_reg;
    logic [LARGURA_DADO-1:0]     ula_dado;
    logic                        ula_pronto;
    logic                        mem_valido;
    logic [4:0]                  mem_reg;
    logic [LARGURA_DADO-1:0]     mem_dado;
    logic                        mem_pronto;
    logic                        congela;
    logic                        regWrite;
    logic [4:0]                  RD;
    logic [LARGURA_DADO-1:0]     dadosEscrita;
    logic [4:0]                  consultaRS;
    logic [4:0]                  consultaRT;
    logic                        acertoRS;
    logic [LARGURA_DADO-1:0]     dadoRS;
    logic                        acertoRT;
    logic [LARGURA_DADO-1:0]     dadoRT;
    logic                        vazio;
    logic                        cheio;
    logic [LARGURA_OCUPACAO-1:0] ocupacao;

    modport master (
        output ula_valido, ula_reg, ula_dado, mem_valido, mem_reg, mem_dado, congela,
               consultaRS, consultaRT,
        input  ula_pronto, mem_pronto, regWrite, RD, dadosEscrita, acertoRS, dadoRS,
               acertoRT, dadoRT, vazio, cheio, ocupacao
    );

    modport slave (
        input  ula_valido, ula_reg, ula_dado, mem_valido, mem_reg, mem_dado, congela,
               consultaRS, consultaRT,
        output ula_pronto, mem_pronto, regWrite, RD, dadosEscrita, acertoRS, dadoRS,
               acertoRT, dadoRT, vazio, cheio, ocupacao
    );
endinterface

// File: rtl/fila_escrita_registradores.sv
// Write-back queue feeding the register file's single write port from the ALU and memory paths.
// Optional bypass lookup of pending writes is built only when ESCRITA_BYPASS_EN is defined.
module fila_escrita_registradores #(
    parameter int unsigned PROFUNDIDADE = 4,
    parameter int unsigned LARGURA_DADO = 32
) (
    input logic                         clock,
    input logic                         reset,
    fila_escrita_registradores_if.slave bus
);
    localparam int unsigned LARGURA_PONTEIRO = $clog2(PROFUNDIDADE);
    localparam int unsigned LARGURA_CONTAGEM = LARGURA_PONTEIRO + 1;
    localparam logic [LARGURA_CONTAGEM-1:0] CAPACIDADE = LARGURA_CONTAGEM'(PROFUNDIDADE);

    logic [4:0]                  registroQ [PROFUNDIDADE];
    logic [LARGURA_DADO-1:0]     dadoQ     [PROFUNDIDADE];
    logic [LARGURA_PONTEIRO-1:0] cabecaQ, cabecaD;
    logic [LARGURA_PONTEIRO-1:0] caudaQ, caudaD;
    logic [LARGURA_PONTEIRO-1:0] posicaoMem;
    logic [LARGURA_CONTAGEM-1:0] contagemQ, contagemD;
    logic [LARGURA_CONTAGEM:0]   contagemComUla;
    logic ulaPronto, memPronto, ulaAceito, memAceito;
    logic ulaGrava, memGrava, retira, vazio;

    always_comb begin
        ulaPronto      = contagemQ < CAPACIDADE;
        ulaAceito      = bus.ula_valido & ulaPronto;
        // Ready ignores a same-cycle drain, so it never depends on congela.
        contagemComUla = {1'b0, contagemQ} + (LARGURA_CONTAGEM + 1)'(ulaAceito);
        memPronto      = contagemComUla < {1'b0, CAPACIDADE};
        memAceito      = bus.mem_valido & memPronto;
        // Writes to register 0 are acknowledged but never stored.
        ulaGrava       = ulaAceito & (bus.ula_reg != 5'd0);
        memGrava       = memAceito & (bus.mem_reg != 5'd0);
        vazio          = contagemQ == '0;
        retira         = !vazio & !bus.congela;
        posicaoMem     = caudaQ + LARGURA_PONTEIRO'(ulaGrava);
        caudaD         = posicaoMem + LARGURA_PONTEIRO'(memGrava);
        cabecaD        = cabecaQ + LARGURA_PONTEIRO'(retira);
        contagemD      = contagemQ + LARGURA_CONTAGEM'(ulaGrava) + LARGURA_CONTAGEM'(memGrava)
                         - LARGURA_CONTAGEM'(retira);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cabecaQ   <= '0;
            caudaQ    <= '0;
            contagemQ <= '0;
            for (int i = 0; i < PROFUNDIDADE; i++) begin
                registroQ[i] <= '0;
                dadoQ[i]     <= '0;
            end
        end else begin
            cabecaQ   <= cabecaD;
            caudaQ    <= caudaD;
            contagemQ <= contagemD;
            if (ulaGrava) begin
                registroQ[caudaQ] <= bus.ula_reg;
                dadoQ[caudaQ]     <= bus.ula_dado;
            end
            if (memGrava) begin
                registroQ[posicaoMem] <= bus.mem_reg;
                dadoQ[posicaoMem]     <= bus.mem_dado;
            end
        end
    end

    assign bus.ula_pronto   = ulaPronto;
    assign bus.mem_pronto   = memPronto;
    assign bus.regWrite     = retira;
    assign bus.RD           = retira ? registroQ[cabecaQ] : 5'd0;
    assign bus.dadosEscrita = retira ? dadoQ[cabecaQ] : '0;
    assign bus.vazio        = vazio;
    assign bus.cheio        = contagemQ == CAPACIDADE;
    assign bus.ocupacao     = contagemQ;

`ifdef ESCRITA_BYPASS_EN
    logic [LARGURA_PONTEIRO-1:0] indice;

    // Walk from head to tail so the newest matching entry overwrites older ones.
    always_comb begin
        bus.acertoRS = 1'b0;
        bus.dadoRS   = '0;
        bus.acertoRT = 1'b0;
        bus.dadoRT   = '0;
        indice       = cabecaQ;
        for (int i = 0; i < PROFUNDIDADE; i++) begin
            indice = cabecaQ + LARGURA_PONTEIRO'(i);
            if (LARGURA_CONTAGEM'(i) < contagemQ) begin
                if (bus.consultaRS != 5'd0 && registroQ[indice] == bus.consultaRS) begin
                    bus.acertoRS = 1'b1;
                    bus.dadoRS   = dadoQ[indice];
                end
                if (bus.consultaRT != 5'd0 && registroQ[indice] == bus.consultaRT) begin
                    bus.acertoRT = 1'b1;
                    bus.dadoRT   = dadoQ[indice];
                end
            end
        end
    end
`else
    logic unusedConsulta;

    assign unusedConsulta = ^{bus.consultaRS, bus.consultaRT};
    assign bus.acertoRS   = 1'b0;
    assign bus.dadoRS     = '0;
    assign bus.acertoRT   = 1'b0;
    assign bus.dadoRT     = '0;
`endif
endmodule

// File: tb/tb_fila_escrita_registradores.sv
// Directed bench for the write-back queue: a cycle-by-cycle vector table plus a reset-mid-drain
// sequence. Bypass expectations follow ESCRITA_BYPASS_EN.
module tb_fila_escrita_registradores;
    localparam int unsigned PROFUNDIDADE = 4;
    localparam int unsigned LARGURA_DADO = 32;
`ifdef ESCRITA_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        logic        ulaValido;
        logic [4:0]  ulaReg;
        logic [31:0] ulaDado;
        logic        memValido;
        logic [4:0]  memReg;
        logic [31:0] memDado;
        logic        congela;
        logic [4:0]  consultaRS;
        logic [4:0]  consultaRT;
        logic        regWrite;
        logic [4:0]  rd;
        logic [31:0] dado;
        logic        ulaPronto;
        logic        memPronto;
        logic [2:0]  ocupacao;
        logic        cheio;
        logic        acertoRS;
        logic [31:0] dadoRS;
        logic        acertoRT;
        logic [31:0] dadoRT;
    } vetor_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   testes = 0;
    int   falhas = 0;

    fila_escrita_registradores_if #(
        .PROFUNDIDADE(PROFUNDIDADE),
        .LARGURA_DADO(LARGURA_DADO)
    ) bus ();

    fila_escrita_registradores #(
        .PROFUNDIDADE(PROFUNDIDADE),
        .LARGURA_DADO(LARGURA_DADO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    task automatic comparar(input string nome, input logic [31:0] atual,
                            input logic [31:0] esperado);
        testes++;
        if (atual !== esperado) begin
            falhas++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nome, atual, esperado);
        end
    endtask

    function automatic vetor_t vet(
        input logic uv, input logic [4:0] ur, input logic [31:0] ud,
        input logic mv, input logic [4:0] mr, input logic [31:0] md,
        input logic cg, input logic [4:0] crs, input logic [4:0] crt,
        input logic rw, input logic [4:0] rd, input logic [31:0] dd,
        input logic up, input logic mp, input logic [2:0] oc, input logic ch,
        input logic ars, input logic [31:0] drs, input logic art, input logic [31:0] drt);
        vetor_t v;
        v.ulaValido = uv; v.ulaReg = ur; v.ulaDado = ud;
        v.memValido = mv; v.memReg = mr; v.memDado = md;
        v.congela = cg; v.consultaRS = crs; v.consultaRT = crt;
        v.regWrite = rw; v.rd = rd; v.dado = dd;
        v.ulaPronto = up; v.memPronto = mp; v.ocupacao = oc; v.cheio = ch;
        v.acertoRS = ars; v.dadoRS = drs; v.acertoRT = art; v.dadoRT = drt;
        return v;
    endfunction

    task automatic aplicar(input logic uv, input logic [4:0] ur, input logic [31:0] ud,
                           input logic mv, input logic [4:0] mr, input logic [31:0] md,
                           input logic cg);
        bus.ula_valido = uv;
        bus.ula_reg    = ur;
        bus.ula_dado   = ud;
        bus.mem_valido = mv;
        bus.mem_reg    = mr;
        bus.mem_dado   = md;
        bus.congela    = cg;
    endtask

    task automatic proximo_ciclo();
        @(posedge clock);
        #1;
    endtask

    vetor_t tabela [20];

    initial begin
        // Each row: inputs held for one cycle, outputs sampled before the closing edge.
        tabela[0]  = vet(0,0,0,          0,0,0,          0, 0,0, 0,0,0,          1,1,0,0, 0,0,0,0);
        tabela[1]  = vet(1,5,32'hDEADBEEF,0,0,0,         0, 5,0, 0,0,0,          1,1,0,0, 0,0,0,0);
        tabela[2]  = vet(0,0,0,          0,0,0,          0, 5,0, 1,5,32'hDEADBEEF,1,1,1,0,
                         1,32'hDEADBEEF,0,0);
        tabela[3]  = vet(1,3,32'h11,     1,3,32'h22,     0, 3,0, 0,0,0,          1,1,0,0, 0,0,0,0);
        tabela[4]  = vet(0,0,0,          0,0,0,          0, 3,3, 1,3,32'h11,     1,1,2,0,
                         1,32'h22,1,32'h22);
        tabela[5]  = vet(0,0,0,          0,0,0,          0, 3,0, 1,3,32'h22,     1,1,1,0,
                         1,32'h22,0,0);
        tabela[6]  = vet(1,1,32'hA1,     1,2,32'hA2,     1, 0,0, 0,0,0,          1,1,0,0, 0,0,0,0);
        tabela[7]  = vet(1,3,32'hA3,     1,4,32'hA4,     1, 1,2, 0,0,0,          1,1,2,0,
                         1,32'hA1,1,32'hA2);
        tabela[8]  = vet(1,5,32'hA5,     1,6,32'hA6,     1, 4,0, 0,0,0,          0,0,4,1,
                         1,32'hA4,0,0);
        tabela[9]  = vet(0,0,0,          0,0,0,          0, 0,0, 1,1,32'hA1,     0,0,4,1, 0,0,0,0);
        tabela[10] = vet(1,5,32'hA5,     1,6,32'hA6,     1, 0,0, 0,0,0,          1,0,3,0, 0,0,0,0);
        tabela[11] = vet(0,0,0,          0,0,0,          0, 5,6, 1,2,32'hA2,     0,0,4,1,
                         1,32'hA5,0,0);
        tabela[12] = vet(0,0,0,          0,0,0,          0, 0,0, 1,3,32'hA3,     1,1,3,0, 0,0,0,0);
        tabela[13] = vet(0,0,0,          0,0,0,          0, 0,0, 1,4,32'hA4,     1,1,2,0, 0,0,0,0);
        tabela[14] = vet(0,0,0,          0,0,0,          0, 0,5, 1,5,32'hA5,     1,1,1,0,
                         0,0,1,32'hA5);
        tabela[15] = vet(1,0,32'h55,     0,0,0,          0, 0,0, 0,0,0,          1,1,0,0, 0,0,0,0);
        tabela[16] = vet(0,0,0,          0,0,0,          0, 0,0, 0,0,0,          1,1,0,0, 0,0,0,0);
        tabela[17] = vet(1,0,32'h55,     1,7,32'h77,     0, 0,0, 0,0,0,          1,1,0,0, 0,0,0,0);
        tabela[18] = vet(0,0,0,          0,0,0,          0, 7,0, 1,7,32'h77,     1,1,1,0,
                         1,32'h77,0,0);
        tabela[19] = vet(0,0,0,          0,0,0,          0, 0,0, 0,0,0,          1,1,0,0, 0,0,0,0);

        aplicar(0, 0, 0, 0, 0, 0, 0);
        bus.consultaRS = 5'd0;
        bus.consultaRT = 5'd0;

        #12;
        comparar("reset regWrite", 32'(bus.regWrite), 0);
        comparar("reset vazio", 32'(bus.vazio), 1);
        comparar("reset cheio", 32'(bus.cheio), 0);
        comparar("reset ocupacao", 32'(bus.ocupacao), 0);
        comparar("reset RD", 32'(bus.RD), 0);
        comparar("reset dadosEscrita", bus.dadosEscrita, 0);
        comparar("reset acertoRS", 32'(bus.acertoRS), 0);

        proximo_ciclo();
        reset = 1'b1;

        for (int i = 0; i < 20; i++) begin
            aplicar(tabela[i].ulaValido, tabela[i].ulaReg, tabela[i].ulaDado,
                    tabela[i].memValido, tabela[i].memReg, tabela[i].memDado, tabela[i].congela);
            bus.consultaRS = tabela[i].consultaRS;
            bus.consultaRT = tabela[i].consultaRT;
            #1;
            comparar($sformatf("v%0d regWrite", i), 32'(bus.regWrite), 32'(tabela[i].regWrite));
            if (tabela[i].regWrite) begin
                comparar($sformatf("v%0d RD", i), 32'(bus.RD), 32'(tabela[i].rd));
                comparar($sformatf("v%0d dadosEscrita", i), bus.dadosEscrita, tabela[i].dado);
            end
            comparar($sformatf("v%0d ula_pronto", i), 32'(bus.ula_pronto),
                     32'(tabela[i].ulaPronto));
            comparar($sformatf("v%0d mem_pronto", i), 32'(bus.mem_pronto),
                     32'(tabela[i].memPronto));
            comparar($sformatf("v%0d ocupacao", i), 32'(bus.ocupacao), 32'(tabela[i].ocupacao));
            comparar($sformatf("v%0d vazio", i), 32'(bus.vazio), 32'(tabela[i].ocupacao == 0));
            comparar($sformatf("v%0d cheio", i), 32'(bus.cheio), 32'(tabela[i].cheio));
            comparar($sformatf("v%0d acertoRS", i), 32'(bus.acertoRS),
                     32'(BYPASS & tabela[i].acertoRS));
            comparar($sformatf("v%0d dadoRS", i), bus.dadoRS,
                     BYPASS ? tabela[i].dadoRS : 32'h0);
            comparar($sformatf("v%0d acertoRT", i), 32'(bus.acertoRT),
                     32'(BYPASS & tabela[i].acertoRT));
            comparar($sformatf("v%0d dadoRT", i), bus.dadoRT,
                     BYPASS ? tabela[i].dadoRT : 32'h0);
            proximo_ciclo();
        end

        // Reset asserted mid-drain with three entries pending.
        aplicar(1, 5'd8, 32'h81, 1, 5'd9, 32'h91, 1);
        proximo_ciclo();
        aplicar(1, 5'd10, 32'h101, 0, 0, 0, 1);
        proximo_ciclo();
        aplicar(0, 0, 0, 0, 0, 0, 0);
        #1;
        comparar("pre-reset ocupacao", 32'(bus.ocupacao), 3);
        comparar("pre-reset regWrite", 32'(bus.regWrite), 1);
        comparar("pre-reset RD", 32'(bus.RD), 8);
        #1;
        reset = 1'b0;
        #1;
        comparar("async reset regWrite", 32'(bus.regWrite), 0);
        comparar("async reset vazio", 32'(bus.vazio), 1);
        comparar("async reset ocupacao", 32'(bus.ocupacao), 0);
        proximo_ciclo();
        comparar("held reset regWrite", 32'(bus.regWrite), 0);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            comparar($sformatf("post-reset %0d regWrite", k), 32'(bus.regWrite), 0);
            comparar($sformatf("post-reset %0d ocupacao", k), 32'(bus.ocupacao), 0);
            proximo_ciclo();
        end

        $display("[TB] %0d tests run, %0d failed", testes, falhas);
        $finish;
    end
endmodule

// File: doc/fila_escrita_registradores.md
Name: fila_escrita_registradores

Overview:
Write-back queue that drives the register file's single write port (regWrite, RD, dadosEscrita) on behalf of two producers: the ALU path and the load/memory path. Producers push write requests with a valid/ready handshake. The queue drains one request per cycle into the register file, in acceptance order. A bypass lookup lets the decode stage read RS/RT values that are still pending in the queue.

Parameters:
PROFUNDIDADE, 4, number of queue entries; must be a power of 2 and at least 2.
LARGURA_DADO, 32, width of write data.

Ports:
clock  input  1  single clock; all state updates on its rising edge
reset  input  1  asynchronous, active-low; clears all state
ula_valido  input  1  ALU path write request valid
ula_reg  input  5  ALU destination register
ula_dado  input  LARGURA_DADO  ALU write data
ula_pronto  output  1  ALU request accepted this cycle when high with ula_valido
mem_valido  input  1  memory path write request valid
mem_reg  input  5  memory destination register
mem_dado  input  LARGURA_DADO  memory write data
mem_pronto  output  1  memory request accepted this cycle when high with mem_valido
congela  input  1  stall: when high, hold the drain (no write issued)
regWrite  output  1  write enable to the register file
RD  output  5  destination register to the register file
dadosEscrita  output  LARGURA_DADO  write data to the register file
consultaRS  input  5  bypass lookup register A
consultaRT  input  5  bypass lookup register B
acertoRS  output  1  a pending write to consultaRS exists
dadoRS  output  LARGURA_DADO  newest pending data for consultaRS
acertoRT  output  1  a pending write to consultaRT exists
dadoRT  output  LARGURA_DADO  newest pending data for consultaRT
vazio  output  1  queue holds 0 entries
cheio  output  1  queue holds PROFUNDIDADE entries
ocupacao  output  $clog2(PROFUNDIDADE)+1  current entry count

Behaviour:
- Storage: circular buffer with a head pointer, a tail pointer and a count. Pointers wrap modulo PROFUNDIDADE.
- Reset (async, reset=0):
  - count and pointers go to 0.
  - regWrite=0, vazio=1, cheio=0, ocupacao=0, acertoRS=acertoRT=0.
  - RD and dadosEscrita are don't-care while regWrite=0, but are driven to 0.
  - Asserting reset mid-operation discards all pending entries immediately.
- Ready:
  - ula_pronto = (count < PROFUNDIDADE).
  - mem_pronto = (count + (ula_valido & ula_pronto)) < PROFUNDIDADE.
  - Ready ignores a same-cycle drain; this is conservative and intentional.
- Enqueue ordering: when both requests are accepted in the same cycle, the ALU entry goes at the tail and the memory entry at tail+1. The ALU write is therefore performed first.
- Register 0:
  - A request with reg=0 is accepted (pronto behaves normally) but is not stored; count is unchanged.
  - A lookup on register 0 never hits.
- Drain:
  - regWrite = !vazio & !congela, driven combinationally.
  - RD and dadosEscrita are taken from the head entry.
  - On each clock edge with regWrite=1, the head advances and count decrements.
- Latency: a request accepted at edge N into an empty queue appears on regWrite/RD during cycle N+1, and the register file commits it at edge N+1.
- Count update per edge: count_next = count + pushes − pop, where pushes is 0–2 and pop is 0–1. Simultaneous push and pop when full is impossible because ready is low when full.
- Bypass lookup:
  - Combinational search over all valid entries, including the head being written this cycle.
  - On multiple matches, the newest (closest to tail) wins.
  - Same-cycle incoming requests are not searched.
- vazio, cheio and ocupacao are derived from the registered count.

Optional Feature:
ESCRITA_BYPASS_EN
- Defined: the bypass lookup is implemented as described in Behaviour.
- Not defined: the lookup logic is omitted, acertoRS=acertoRT=0 and dadoRS=dadoRT=0. Ports remain present.

Test Plan:
- Reset then idle → regWrite=0, vazio=1, ocupacao=0; dropping reset mid-drain with 3 entries pending → regWrite=0 immediately and no further writes.
- Single ALU push (reg 5, 0xDEADBEEF) at edge N → cycle N+1: regWrite=1, RD=5, dadosEscrita=0xDEADBEEF; vazio=1 after edge N+1.
- Simultaneous ALU (reg 3, 0x11) and memory (reg 3, 0x22) pushes into an empty queue → two consecutive writes, 0x11 then 0x22. While both are pending, a lookup of consultaRS=3 gives acertoRS=1, dadoRS=0x22.
- congela=1 while the queue fills with PROFUNDIDADE=4 pushes → cheio=1, ula_pronto=0 and mem_pronto=0; the 5th request is held. Releasing congela drains in FIFO order, one entry per cycle.
- Count=3, both producers valid → ALU accepted, mem_pronto=0, cheio=1 next cycle.
- Push to reg 0 (data 0x55) → accepted, ocupacao unchanged, no regWrite pulse; consultaRT=0 gives acertoRT=0.
